// File: rtl/usb_tx_pkg.sv
// Shared types and constants for the USB transmit word buffer.
package usb_tx_pkg;

  localparam int WORD_W         = 64;
  localparam int BYTE_W         = 8;
  localparam int BYTES_PER_WORD = 8;

  typedef logic [WORD_W-1:0] tx_word_t;

  // Bit offset of byte lane 'lane' inside a word (lane 0 is the least significant byte).
  function automatic logic [5:0] lane_offset(input logic [2:0] lane);
    return {lane, 3'b000};
  endfunction

endpackage

// File: rtl/tx_word_fifo.sv
// Small register-based FIFO of 64-bit words. The head word is read
// combinationally from the storage registers. A push while full and a pop
// while empty are ignored.
module tx_word_fifo
  import usb_tx_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     n_rst,
  input  logic                     push,
  input  tx_word_t                 wdata,
  input  logic                     pop,
  output tx_word_t                 rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [AW-1:0] PTR_ONE = AW'(1'b1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1'b1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEPTH);

  tx_word_t        mem_q [DEPTH];
  tx_word_t        mem_d [DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            do_push;
  logic            do_pop;

  assign full  = (count_q == CNT_MAX);
  assign empty = (count_q == {CW{1'b0}});
  assign count = count_q;
  assign rdata = mem_q[rd_ptr_q];

  // Next-state computation for storage, pointers and occupancy.
  always_comb begin
    do_push  = push && !full;
    do_pop   = pop && !empty;
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = wdata;
      wr_ptr_d        = wr_ptr_q + PTR_ONE;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  // State registers with synchronous active-low reset; storage cleared so the head reads zero.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= {WORD_W{1'b0}};
      end
      wr_ptr_q <= {AW{1'b0}};
      rd_ptr_q <= {AW{1'b0}};
      count_q  <= {CW{1'b0}};
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/tx_word_buffer.sv
// Packs the encryption byte stream into 64-bit words (LSB first), queues them,
// and presents the head word to the USB transmitter.
// Optional macro TX_BUF_LEVEL_EN adds the 'level' output (registered word count).
module tx_word_buffer
  import usb_tx_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      n_rst,
  input  logic [BYTE_W-1:0]         byte_in,
  input  logic                      byte_valid,
  output logic                      byte_ready,
  input  logic                      flush,
  output tx_word_t                  trans_data,
  output logic                      trans_data_ready,
  input  logic                      handshake_ack
`ifdef TX_BUF_LEVEL_EN
  ,
  output logic [$clog2(DEPTH):0]    level
`endif
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [2:0] LAST_LANE = 3'(BYTES_PER_WORD - 1);

  logic [2:0]      fill_q, fill_d;
  tx_word_t        asm_q, asm_d;
  logic            flush_pending_q, flush_pending_d;

  logic            accept;
  tx_word_t        word_with;
  logic            fifo_push;
  logic            fifo_pop;
  logic            fifo_full;
  logic            fifo_empty;
  logic [CW-1:0]   fifo_count;

  // Backpressure only depends on registered state: block the 8th byte when the
  // word would have nowhere to go, and stall completely while a flush waits.
  always_comb begin
    byte_ready = !((fill_q == LAST_LANE) && fifo_full) && !flush_pending_q;
    accept     = byte_valid && byte_ready;
    fifo_pop   = handshake_ack && !fifo_empty;
  end

  // Assembler and flush control: decide what enters the FIFO this edge.
  // The assembly register is cleared after every push, so unfilled lanes are
  // already zero and padding needs no extra masking.
  always_comb begin
    word_with = asm_q;
    if (accept) begin
      word_with[lane_offset(fill_q) +: BYTE_W] = byte_in;
    end else begin
      word_with = asm_q;
    end

    fill_d          = fill_q;
    asm_d           = word_with;
    flush_pending_d = flush_pending_q;
    fifo_push       = 1'b0;

    if (accept && (fill_q == LAST_LANE)) begin
      // Word completed by this byte; a simultaneous flush adds nothing.
      fifo_push = 1'b1;
      fill_d    = 3'd0;
      asm_d     = {WORD_W{1'b0}};
    end else if (flush_pending_q) begin
      if (!fifo_full) begin
        fifo_push       = 1'b1;
        fill_d          = 3'd0;
        asm_d           = {WORD_W{1'b0}};
        flush_pending_d = 1'b0;
      end else begin
        flush_pending_d = 1'b1;
      end
    end else if (flush && (accept || (fill_q != 3'd0))) begin
      if (!fifo_full) begin
        fifo_push = 1'b1;
        fill_d    = 3'd0;
        asm_d     = {WORD_W{1'b0}};
      end else begin
        flush_pending_d = 1'b1;
        fill_d          = fill_q + {2'b00, accept};
      end
    end else begin
      fill_d = fill_q + {2'b00, accept};
    end
  end

  // Assembler state registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      fill_q          <= 3'd0;
      asm_q           <= {WORD_W{1'b0}};
      flush_pending_q <= 1'b0;
    end else begin
      fill_q          <= fill_d;
      asm_q           <= asm_d;
      flush_pending_q <= flush_pending_d;
    end
  end

  tx_word_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .n_rst (n_rst),
    .push  (fifo_push),
    .wdata (word_with),
    .pop   (fifo_pop),
    .rdata (trans_data),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign trans_data_ready = (fifo_count != {CW{1'b0}});

`ifdef TX_BUF_LEVEL_EN
  assign level = fifo_count;
`endif

endmodule
